// File: rtl/dvp_config_master_if.sv
// Bundle of the controller-side command/response handshake and the AXI4
// configuration channels of dvp_config_master.
// master: the view of dvp_config_master. slave: the controller plus AXI slave.
interface dvp_config_master_if #(
    parameter int MST_ID_W     = 5,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TRANS_RESP_W = 2
);
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic                    cmd_wr_i;
    logic [ADDR_W-1:0]       cmd_addr_i;
    logic [DATA_W-1:0]       cmd_wdata_i;

    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic                    rsp_wr_o;
    logic [TRANS_RESP_W-1:0] rsp_resp_o;
    logic [DATA_W-1:0]       rsp_rdata_o;

    logic [MST_ID_W-1:0]     m_awid_o;
    logic [ADDR_W-1:0]       m_awaddr_o;
    logic                    m_awvalid_o;
    logic                    m_awready_i;
    logic [DATA_W-1:0]       m_wdata_o;
    logic                    m_wvalid_o;
    logic                    m_wready_i;
    logic [TRANS_RESP_W-1:0] m_bresp_i;
    logic                    m_bvalid_i;
    logic                    m_bready_o;
    logic [MST_ID_W-1:0]     m_arid_o;
    logic [ADDR_W-1:0]       m_araddr_o;
    logic                    m_arvalid_o;
    logic                    m_arready_i;
    logic [DATA_W-1:0]       m_rdata_i;
    logic                    m_rvalid_i;
    logic                    m_rready_o;

    modport master (
        input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
               m_awready_i, m_wready_i, m_bresp_i, m_bvalid_i,
               m_arready_i, m_rdata_i, m_rvalid_i,
        output cmd_ready_o, rsp_valid_o, rsp_wr_o, rsp_resp_o, rsp_rdata_o,
               m_awid_o, m_awaddr_o, m_awvalid_o, m_wdata_o, m_wvalid_o,
               m_bready_o, m_arid_o, m_araddr_o, m_arvalid_o, m_rready_o
    );

    modport slave (
        output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
               m_awready_i, m_wready_i, m_bresp_i, m_bvalid_i,
               m_arready_i, m_rdata_i, m_rvalid_i,
        input  cmd_ready_o, rsp_valid_o, rsp_wr_o, rsp_resp_o, rsp_rdata_o,
               m_awid_o, m_awaddr_o, m_awvalid_o, m_wdata_o, m_wvalid_o,
               m_bready_o, m_arid_o, m_araddr_o, m_arvalid_o, m_rready_o
    );
endinterface

// File: rtl/dvp_config_master.sv
// dvp_config_master: turns single-beat register commands into one AXI4 write
// (AW/W/B) or read (AR/R) at a time and returns one response beat per command.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready_o high
// WR_REQ  | offering AW and W independently until both have handshaken
// WR_RESP | bready high, waiting for the write response
// RD_REQ  | arvalid high until arready
// RD_RESP | rready high, waiting for read data
// RSP     | response beat held stable until rsp_ready_i
module dvp_config_master #(
    parameter int                  MST_ID_W     = 5,
    parameter int                  ADDR_W       = 32,
    parameter int                  DATA_W       = 32,
    parameter int                  TRANS_RESP_W = 2,
    parameter logic [MST_ID_W-1:0] MST_ID       = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dvp_config_master_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_wr;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [TRANS_RESP_W-1:0] r_resp;
    logic [DATA_W-1:0]       r_rdata;

    logic                    w_cmd_hs;
    logic                    w_awvalid;
    logic                    w_wvalid;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_aw_ok;
    logic                    w_w_ok;

    // Valids come from state and done flags only, never from the readys.
    assign w_awvalid = (r_state == WR_REQ) && !r_aw_done;
    assign w_wvalid  = (r_state == WR_REQ) && !r_w_done;
    assign w_cmd_hs  = (r_state == IDLE) && bus.cmd_valid_i;
    assign w_aw_hs   = w_awvalid && bus.m_awready_i;
    assign w_w_hs    = w_wvalid && bus.m_wready_i;
    assign w_aw_ok   = r_aw_done || w_aw_hs;
    assign w_w_ok    = r_w_done || w_w_hs;

    assign bus.cmd_ready_o = (r_state == IDLE);
    assign bus.rsp_valid_o = (r_state == RSP);
    assign bus.rsp_wr_o    = r_wr;
    assign bus.rsp_resp_o  = r_resp;
    assign bus.rsp_rdata_o = r_rdata;

    assign bus.m_awid_o    = MST_ID;
    assign bus.m_awaddr_o  = r_addr;
    assign bus.m_awvalid_o = w_awvalid;
    assign bus.m_wdata_o   = r_wdata;
    assign bus.m_wvalid_o  = w_wvalid;
    assign bus.m_bready_o  = (r_state == WR_RESP);
    assign bus.m_arid_o    = MST_ID;
    assign bus.m_araddr_o  = r_addr;
    assign bus.m_arvalid_o = (r_state == RD_REQ);
    assign bus.m_rready_o  = (r_state == RD_RESP);

    // State register; reset drops every valid asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cmd_hs)         w_next = bus.cmd_wr_i ? WR_REQ : RD_REQ;
            WR_REQ:  if (w_aw_ok && w_w_ok) w_next = WR_RESP;
            WR_RESP: if (bus.m_bvalid_i)   w_next = RSP;
            RD_REQ:  if (bus.m_arready_i)  w_next = RD_RESP;
            RD_RESP: if (bus.m_rvalid_i)   w_next = RSP;
            RSP:     if (bus.rsp_ready_i)  w_next = IDLE;
            default:                       w_next = IDLE;
        endcase
    end

    // Command latch, handshake flags and response capture. Response fields
    // are cleared at command accept so writes return rdata 0 and reads resp 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr      <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_resp    <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        r_addr    <= bus.cmd_addr_i;
                        r_wdata   <= bus.cmd_wdata_i;
                        r_wr      <= bus.cmd_wr_i;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_resp    <= '0;
                        r_rdata   <= '0;
                    end
                end
                WR_REQ: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (bus.m_bvalid_i) r_resp <= bus.m_bresp_i;
                end
                RD_RESP: begin
                    if (bus.m_rvalid_i) r_rdata <= bus.m_rdata_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_config_master.sv
// Bench for dvp_config_master: directed vector table, hand-written corner
// sequences and random transactions against a memory-map reference model.
module tb_dvp_config_master;

    localparam logic [4:0] TB_ID = 5'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dvp_config_master_if #(.MST_ID_W(5), .ADDR_W(32), .DATA_W(32), .TRANS_RESP_W(2)) bus ();

    dvp_config_master #(
        .MST_ID_W(5), .ADDR_W(32), .DATA_W(32), .TRANS_RESP_W(2), .MST_ID(TB_ID)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave address map: bit 4 set means unmapped (BRESP 11, write dropped);
    // never-written locations read back addr ^ A5A5A5A5.
    function automatic bit unmapped(input logic [31:0] a);
        return a[4];
    endfunction
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    // ---------------- AXI slave (drives at negedge) ----------------
    int cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_hs_next, w_hs_next, b_hs_next, ar_hs_next, r_hs_next;
    bit got_aw, got_w, got_ar;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [31:0] s_mem [logic [31:0]];

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.m_awready_i = 0; bus.m_wready_i = 0; bus.m_arready_i = 0;
            bus.m_bvalid_i = 0; bus.m_bresp_i = 0; bus.m_rvalid_i = 0; bus.m_rdata_i = 0;
            aw_hs_next = 0; w_hs_next = 0; b_hs_next = 0; ar_hs_next = 0; r_hs_next = 0;
            got_aw = 0; got_w = 0; got_ar = 0;
            aw_cnt = cfg_aw_d; w_cnt = cfg_w_d; b_cnt = cfg_b_d; ar_cnt = cfg_ar_d; r_cnt = cfg_r_d;
            s_mem[32'h4000_0000] = 32'h0000_1234;
        end else begin
            if (aw_hs_next) begin bus.m_awready_i = 0; aw_hs_next = 0; got_aw = 1; end
            else if (bus.m_awvalid_o) begin
                if (aw_cnt == 0) begin bus.m_awready_i = 1; aw_hs_next = 1; s_awaddr = bus.m_awaddr_o; end
                else aw_cnt--;
            end else aw_cnt = cfg_aw_d;

            if (w_hs_next) begin bus.m_wready_i = 0; w_hs_next = 0; got_w = 1; end
            else if (bus.m_wvalid_o) begin
                if (w_cnt == 0) begin bus.m_wready_i = 1; w_hs_next = 1; s_wdata = bus.m_wdata_o; end
                else w_cnt--;
            end else w_cnt = cfg_w_d;

            if (b_hs_next) begin bus.m_bvalid_i = 0; b_hs_next = 0; end
            else if (bus.m_bvalid_i) begin
                if (bus.m_bready_o) b_hs_next = 1;
            end else if (got_aw && got_w) begin
                if (b_cnt == 0) begin
                    bus.m_bvalid_i = 1;
                    bus.m_bresp_i = unmapped(s_awaddr) ? 2'b11 : 2'b00;
                    if (!unmapped(s_awaddr)) s_mem[s_awaddr] = s_wdata;
                    got_aw = 0; got_w = 0;
                    if (bus.m_bready_o) b_hs_next = 1;
                end else b_cnt--;
            end else b_cnt = cfg_b_d;

            if (ar_hs_next) begin bus.m_arready_i = 0; ar_hs_next = 0; got_ar = 1; end
            else if (bus.m_arvalid_o) begin
                if (ar_cnt == 0) begin bus.m_arready_i = 1; ar_hs_next = 1; s_araddr = bus.m_araddr_o; end
                else ar_cnt--;
            end else ar_cnt = cfg_ar_d;

            if (r_hs_next) begin bus.m_rvalid_i = 0; r_hs_next = 0; end
            else if (bus.m_rvalid_i) begin
                if (bus.m_rready_o) r_hs_next = 1;
            end else if (got_ar) begin
                if (r_cnt == 0) begin
                    bus.m_rvalid_i = 1;
                    bus.m_rdata_i = s_mem.exists(s_araddr) ? s_mem[s_araddr] : dflt(s_araddr);
                    got_ar = 0;
                    if (bus.m_rready_o) r_hs_next = 1;
                end else r_cnt--;
            end else r_cnt = cfg_r_d;
        end
    end

    // ---------------- protocol monitor (values seen by the next posedge) ----------------
    int aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0;
    logic [31:0] mon_awaddr, mon_wdata, mon_araddr;
    logic [4:0]  mon_awid, mon_arid;
    logic p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0, p_arvalid = 0, p_arready = 0;
    logic p_bready = 0, p_bvalid = 0, p_rready = 0, p_rvalid = 0;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0;
            p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_arvalid = 0; p_arready = 0;
            p_bready = 0; p_bvalid = 0; p_rready = 0; p_rvalid = 0;
        end else begin
            if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0;
            end
            if (p_awvalid && !p_awready) check("aw_hold", {bus.m_awvalid_o, bus.m_awaddr_o}, {1'b1, p_awaddr});
            if (p_wvalid && !p_wready)   check("w_hold", {bus.m_wvalid_o, bus.m_wdata_o}, {1'b1, p_wdata});
            if (p_arvalid && !p_arready) check("ar_hold", {bus.m_arvalid_o, bus.m_araddr_o}, {1'b1, p_araddr});
            if (p_awvalid && p_awready)  check("aw_drop", bus.m_awvalid_o, 1'b0);
            if (p_wvalid && p_wready)    check("w_drop", bus.m_wvalid_o, 1'b0);
            if (p_arvalid && p_arready)  check("ar_drop", bus.m_arvalid_o, 1'b0);
            if (p_bready && !p_bvalid)   check("bready_hold", bus.m_bready_o, 1'b1);
            if (p_rready && !p_rvalid)   check("rready_hold", bus.m_rready_o, 1'b1);
            if (bus.m_bready_o)          check("b_after_aw_w", {aw_beats == 1, w_beats == 1}, 2'b11);

            if (bus.m_awvalid_o && bus.m_awready_i) begin aw_beats++; mon_awaddr = bus.m_awaddr_o; mon_awid = bus.m_awid_o; end
            if (bus.m_wvalid_o && bus.m_wready_i)   begin w_beats++; mon_wdata = bus.m_wdata_o; end
            if (bus.m_bvalid_i && bus.m_bready_o)   b_beats++;
            if (bus.m_arvalid_o && bus.m_arready_i) begin ar_beats++; mon_araddr = bus.m_araddr_o; mon_arid = bus.m_arid_o; end
            if (bus.m_rvalid_i && bus.m_rready_o)   r_beats++;

            p_awvalid = bus.m_awvalid_o; p_awready = bus.m_awready_i; p_awaddr = bus.m_awaddr_o;
            p_wvalid = bus.m_wvalid_o;   p_wready = bus.m_wready_i;   p_wdata = bus.m_wdata_o;
            p_arvalid = bus.m_arvalid_o; p_arready = bus.m_arready_i; p_araddr = bus.m_araddr_o;
            p_bready = bus.m_bready_o;   p_bvalid = bus.m_bvalid_i;
            p_rready = bus.m_rready_o;   p_rvalid = bus.m_rvalid_i;
        end
    end

    // ---------------- controller-side tasks ----------------
    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data, output int waits);
        bus.cmd_valid_i = 1; bus.cmd_wr_i = wr; bus.cmd_addr_i = addr; bus.cmd_wdata_i = data;
        waits = 0;
        while (!bus.cmd_ready_o && waits < 100) begin @(negedge clk); waits++; end
        check("cmd_accept", bus.cmd_ready_o, 1'b1);
        @(negedge clk);
        bus.cmd_valid_i = 0;
    endtask

    task automatic recv_rsp(input int hold, output logic r_wr, output logic [1:0] r_resp,
                            output logic [31:0] r_rdata, output int lat);
        lat = 0;
        while (!bus.rsp_valid_o && lat < 100) begin @(negedge clk); lat++; end
        check("rsp_valid", bus.rsp_valid_o, 1'b1);
        r_wr = bus.rsp_wr_o; r_resp = bus.rsp_resp_o; r_rdata = bus.rsp_rdata_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_stable", {bus.rsp_valid_o, bus.rsp_wr_o, bus.rsp_resp_o, bus.rsp_rdata_o},
                  {1'b1, r_wr, r_resp, r_rdata});
            check("cmd_ready_in_rsp", bus.cmd_ready_o, 1'b0);
        end
        bus.rsp_ready_i = 1;
        @(negedge clk);
        bus.rsp_ready_i = 0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_d, w_d, b_d, ar_d, r_d, hold;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    logic [31:0] model_mem [logic [31:0]];

    task automatic run_vec(input vec_t v);
        int cw, lat;
        logic rw;
        logic [1:0] rr;
        logic [31:0] rd;
        cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d; cfg_ar_d = v.ar_d; cfg_r_d = v.r_d;
        @(negedge clk);
        send_cmd(v.wr, v.addr, v.wdata, cw);
        recv_rsp(v.hold, rw, rr, rd, lat);
        check("rsp_fields", {rw, rr, rd}, {v.wr, v.exp_resp, v.exp_rdata});
        check("beat_counts", {4'(aw_beats), 4'(w_beats), 4'(b_beats), 4'(ar_beats), 4'(r_beats)},
              v.wr ? 20'h11100 : 20'h00011);
        if (v.wr) check("aw_w_payload", {mon_awid, mon_awaddr, mon_wdata}, {TB_ID, v.addr, v.wdata});
        else      check("ar_payload", {mon_arid, mon_araddr}, {TB_ID, v.addr});
        if (v.exp_lat >= 0) check("rsp_latency", lat, v.exp_lat);
        if (v.wr && !unmapped(v.addr)) model_mem[v.addr] = v.wdata;
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [8];

    initial begin
        int cw, lat;
        bit seen;
        logic rw;
        logic [1:0] rr;
        logic [31:0] rd;
        vec_t v;

        bus.cmd_valid_i = 0; bus.cmd_wr_i = 0; bus.cmd_addr_i = 0; bus.cmd_wdata_i = 0; bus.rsp_ready_i = 0;
        model_mem[32'h4000_0000] = 32'h0000_1234;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
        check("rst_valids", {bus.m_awvalid_o, bus.m_wvalid_o, bus.m_arvalid_o, bus.m_bready_o,
                             bus.m_rready_o, bus.rsp_valid_o}, 6'b0);
        check("rst_rsp", {bus.rsp_wr_o, bus.rsp_resp_o, bus.rsp_rdata_o}, 35'h0);
        check("rst_addr_data", {bus.m_awaddr_o, bus.m_araddr_o, bus.m_wdata_o}, 96'h0);
        rst_n = 1;
        @(negedge clk);

        //            wr  addr            wdata          aw w  b  ar r  hold resp   rdata          lat
        vecs[0] = '{1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,         2};
        vecs[1] = '{1'b1, 32'h4000_0008, 32'h0BAD_F00D, 3, 0, 0, 0, 0, 0, 2'b00, 32'h0,        -1};
        vecs[2] = '{1'b1, 32'h4000_0010, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 2'b11, 32'h0,        -1};
        vecs[3] = '{1'b0, 32'h4000_0000, 32'h0,         0, 0, 0, 0, 5, 0, 2'b00, 32'h0000_1234, -1};
        vecs[4] = '{1'b0, 32'h4000_0004, 32'h0,         0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 2};
        vecs[5] = '{1'b0, 32'h4000_0008, 32'h0,         0, 0, 0, 2, 0, 1, 2'b00, 32'h0BAD_F00D, -1};
        vecs[6] = '{1'b0, 32'h4000_0010, 32'h0,         0, 0, 0, 0, 0, 0, 2'b00, 32'hE5A5_A5B5, -1};
        vecs[7] = '{1'b1, 32'h4000_000C, 32'h7777_0001, 0, 2, 3, 0, 0, 2, 2'b00, 32'h0,        -1};
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Response back-pressure with the next command already waiting.
        cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
        @(negedge clk);
        send_cmd(1'b1, 32'h4000_0028, 32'hCAFE_0001, cw);
        bus.cmd_valid_i = 1; bus.cmd_wr_i = 0; bus.cmd_addr_i = 32'h4000_0028; bus.cmd_wdata_i = 0;
        recv_rsp(4, rw, rr, rd, lat);
        check("bp_write_rsp", {rw, rr, rd}, {1'b1, 2'b00, 32'h0});
        model_mem[32'h4000_0028] = 32'hCAFE_0001;
        check("bp_cmd_ready_after_rsp", bus.cmd_ready_o, 1'b1);
        send_cmd(1'b0, 32'h4000_0028, 32'h0, cw);
        check("bp_accept_wait", cw, 0);
        recv_rsp(0, rw, rr, rd, lat);
        check("bp_read_rsp", {rw, rr, rd}, {1'b0, 2'b00, 32'hCAFE_0001});

        // Reset pulse while waiting for B; the write is abandoned.
        cfg_b_d = 20;
        @(negedge clk);
        send_cmd(1'b1, 32'h4000_0020, 32'h5555_AAAA, cw);
        lat = 0;
        while (!bus.m_bready_o && lat < 50) begin @(negedge clk); lat++; end
        check("reach_wr_resp", bus.m_bready_o, 1'b1);
        #2 rst_n = 0;
        #1;
        check("async_rst_valids", {bus.m_awvalid_o, bus.m_wvalid_o, bus.m_arvalid_o, bus.m_bready_o,
                                   bus.m_rready_o, bus.rsp_valid_o}, 6'b0);
        check("async_rst_cmd_ready", bus.cmd_ready_o, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        cfg_b_d = 0;
        seen = 0;
        repeat (10) begin @(negedge clk); if (bus.rsp_valid_o) seen = 1; end
        check("no_rsp_after_rst", seen, 1'b0);
        check("cmd_ready_after_rst", bus.cmd_ready_o, 1'b1);
        v = '{1'b0, 32'h4000_0020, 32'h0, 0, 0, 0, 0, 1, 0, 2'b00, 32'hE5A5_A585, -1};
        run_vec(v);

        // Random traffic against the memory-map model.
        for (int i = 0; i < 150; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
            v.wdata = $urandom;
            v.aw_d  = $urandom_range(0, 4);
            v.w_d   = $urandom_range(0, 4);
            v.b_d   = $urandom_range(0, 4);
            v.ar_d  = $urandom_range(0, 4);
            v.r_d   = $urandom_range(0, 4);
            v.hold  = $urandom_range(0, 2);
            v.exp_lat = -1;
            if (v.wr) begin
                v.exp_resp  = unmapped(v.addr) ? 2'b11 : 2'b00;
                v.exp_rdata = 32'h0;
            end else begin
                v.exp_resp  = 2'b00;
                v.exp_rdata = model_mem.exists(v.addr) ? model_mem[v.addr] : dflt(v.addr);
            end
            run_vec(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
